// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port (MSB first), length (MSB first), then payload LSB first.
// One bit period ends on every clk edge that sees bit_en high; all outputs are registered.
module serial_frame_tx #(
   parameter  int PORT_W = 2,
   parameter  int LEN_W  = 4,
   localparam int DATA_W = 2**LEN_W - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              start,
   input  logic [PORT_W-1:0] port_num,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [DATA_W-1:0] data_in,
   output logic              SerOut,
   output logic              busy,
   output logic              ser_out_valid,
   output logic              done,
   output logic [LEN_W-1:0]  bits_left
);

   localparam int IDX_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PORT,
      S_LEN,
      S_DATA
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [PORT_W-1:0]   r_port_sh;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_len_sh;
   logic [DATA_W-1:0]   r_data_sh;
   logic [LEN_W-1:0]    r_bits_left;
   logic                r_ser;
   logic                r_busy;
   logic                r_valid;
   logic                r_done;

   logic [PORT_W-1:0]   w_port_shl;
   logic [LEN_W-1:0]    w_len_shl;
   logic [DATA_W-1:0]   w_data_shr;

   // The next bit to drive is read from the already-shifted copy so SerOut stays registered.
   assign w_port_shl = r_port_sh << 1;
   assign w_len_shl  = r_len_sh << 1;
   assign w_data_shr = r_data_sh >> 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_port_sh   <= '0;
         r_len       <= '0;
         r_len_sh    <= '0;
         r_data_sh   <= '0;
         r_bits_left <= '0;
         r_ser       <= 1'b1;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ser   <= 1'b1;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               if (start) begin
                  r_port_sh   <= port_num;
                  r_len       <= data_len;
                  r_len_sh    <= data_len;
                  r_data_sh   <= data_in;
                  r_bits_left <= data_len;
                  r_ser       <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_START;
               end
            end
            S_START: begin
               if (bit_en) begin
                  r_idx   <= IDX_W'(PORT_W - 1);
                  r_ser   <= r_port_sh[PORT_W-1];
                  r_state <= S_PORT;
               end
            end
            S_PORT: begin
               if (bit_en) begin
                  if (r_idx == '0) begin
                     r_idx   <= IDX_W'(LEN_W - 1);
                     r_ser   <= r_len_sh[LEN_W-1];
                     r_state <= S_LEN;
                  end else begin
                     r_idx     <= r_idx - 1'b1;
                     r_port_sh <= w_port_shl;
                     r_ser     <= w_port_shl[PORT_W-1];
                  end
               end
            end
            S_LEN: begin
               if (bit_en) begin
                  if (r_idx == '0) begin
                     if (r_len != '0) begin
                        r_bits_left <= r_len;
                        r_ser       <= r_data_sh[0];
                        r_valid     <= 1'b1;
                        r_state     <= S_DATA;
                     end else begin
                        r_ser   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_idx    <= r_idx - 1'b1;
                     r_len_sh <= w_len_shl;
                     r_ser    <= w_len_shl[LEN_W-1];
                  end
               end
            end
            S_DATA: begin
               if (bit_en) begin
                  r_bits_left <= r_bits_left - 1'b1;
                  if (r_bits_left == LEN_W'(1)) begin
                     r_ser   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_data_sh <= w_data_shr;
                     r_ser     <= w_data_shr[0];
                  end
               end
            end
            default: begin
               r_ser   <= 1'b1;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign SerOut        = r_ser;
   assign busy          = r_busy;
   assign ser_out_valid = r_valid;
   assign done          = r_done;
   assign bits_left     = r_bits_left;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Serial frame transmitter that produces the port-addressed serial stream consumed by the team's serial demux receiver.
- Each frame carries: start bit, port number, payload length, payload bits.
- Bits advance one per bit_en pulse, so the stream can be paced by the same one-pulsed clock enable that paces the receiver, or run at one bit per clk.
- Sits between a host/test controller and the receiver's SerIn.

Parameters:
PORT_W, 2, port-number width (receiver has 2^PORT_W ports)
LEN_W, 4, length-field width; payload holds up to 2^LEN_W-1 bits
DATA_W, 2**LEN_W-1 (15), payload register width; derived, do not override

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
bit_en  input  1  bit-period strobe; each cycle it is high ends the current bit period
start  input  1  frame request, sampled only in IDLE
port_num  input  PORT_W  destination port, latched on accepted start
data_len  input  LEN_W  payload bit count N (0..15), latched on accepted start
data_in  input  DATA_W  payload, latched on accepted start; bit 0 is sent first
SerOut  output  1  serial line; idles high
busy  output  1  high from the cycle after start is accepted until the done cycle
ser_out_valid  output  1  high while SerOut carries a payload bit
done  output  1  one-clk pulse at end of frame
bits_left  output  LEN_W  payload bits not yet completed

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, SerOut=1, busy=0, ser_out_valid=0, done=0, bits_left=0, all latches cleared.
- Frame on the line: 0 (start), then port_num MSB first, then data_len MSB first, then data_in[0..N-1]; line returns to 1.
- Total bit periods per frame: 1+PORT_W+LEN_W+N (7+N at defaults).
- All outputs are registered.
- States:
  - IDLE: SerOut=1. On start=1, latch inputs and go to START on the same edge; bit_en is irrelevant in IDLE.
  - START: SerOut=0 until an edge with bit_en=1, then go to PORT with an index counter at PORT_W-1.
  - PORT: SerOut=port[idx]. On bit_en, idx decrements. After idx 0, go to LEN with idx at LEN_W-1.
  - LEN: SerOut=len[idx], same stepping. After idx 0: go to DATA if N>0, else go to IDLE with done.
  - DATA: SerOut=data[k] with k counting from 0; ser_out_valid=1. On bit_en, k increments and bits_left decrements. When bits_left reaches 0, go to IDLE with done.
- bits_left loads N on entry to DATA (same edge as leaving LEN). It reads N during START/PORT/LEN and decrements after each completed payload bit.
- done=1 for exactly the one cycle after the final bit period ends. In that cycle: SerOut=1, busy=0, ser_out_valid=0, state=IDLE.
- start is accepted in the done cycle, giving back-to-back frames with one idle-high clk between them.
- start while busy is ignored, with no effect on the frame or the latched values; input changes while busy are also ignored.
- bit_en held high continuously gives exactly one bit per clk.
- bit_en low freezes the state and SerOut indefinitely.
- Reset mid-frame aborts immediately to the reset values with no done pulse; the next frame requires a new start.

Test Plan:
1. port_num=2'b10, data_len=3, data_in=...101, bit_en always 1 -> SerOut over 10 clks after accept = 0,1,0,0,0,1,1,1,0,1. Then 1 with done=1 for one clk; ser_out_valid high on the last 3 bits only; bits_left 3,2,1 during DATA, 0 at done.
2. port_num=2'b01, data_len=0, pulse start -> 7 bit periods 0,0,1,0,0,0,0; ser_out_valid never high; done after the 7th period.
3. bit_en pulsed every 4th clk, data_len=15, data_in=15'h7FFF -> each bit holds exactly 4 clks; 22 bit periods; SerOut=1 for all 15 payload bits; done once.
4. start re-asserted with different port/len/data mid-frame -> the frame in flight is bit-identical to one sent with no extra start; no second frame follows.
5. rst driven low during DATA bit 2 -> outputs reach reset values asynchronously; no done; new start sends a clean full frame.
6. start held high continuously, data_len=1 -> frames repeat with exactly one SerOut=1 clk (the done cycle) between consecutive start bits.
